// File: rtl/wormhole_rr_allocator.sv
// Round-robin, packet-locked output-channel allocator for one BiNoC output port.
// Optional stall watchdog (adds output wd_trip) is built when WATCHDOG_EN is defined.
module wormhole_rr_allocator #(
    parameter int NREQ     = 10,
    parameter int SELW     = 4,
    parameter int CREDITS  = 4,
    parameter int CW       = 3,
    parameter int WD_LIMIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] tail,
    input  logic            credit_in,
    output logic [NREQ-1:0] gnt,
    output logic [SELW-1:0] sel,
    output logic            fwd,
    output logic            busy,
    output logic [CW-1:0]   credit_cnt,
    output logic            credit_err
`ifdef WATCHDOG_EN
    ,
    output logic            wd_trip
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [SELW-1:0] LAST_IDX  = SELW'(NREQ - 1);
    localparam logic [SELW-1:0] ONE_IDX   = SELW'(1);
    localparam logic [SELW:0]   NREQ_EXT  = (SELW + 1)'(NREQ);
    localparam logic [CW-1:0]   CRED_MAX  = CW'(CREDITS);
    localparam logic [CW-1:0]   CRED_ONE  = CW'(1);
    localparam logic [NREQ-1:0] GNT_ONE   = NREQ'(1);

    logic [0:0]      state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]   credit_cnt_q, credit_cnt_d;
    logic            credit_err_q, credit_err_d;

    logic [NREQ-1:0] req_rot;
    logic [SELW-1:0] pick_off;
    logic [SELW:0]   pick_sum;
    logic [SELW-1:0] pick;
    logic            owner_req;
    logic            owner_tail;
    logic            pkt_done;
    logic            wd_fire;

    // Handshake: req is a level "flit available"; a flit moves downstream in
    // exactly the cycles where fwd=1 (owner requesting and a credit held);
    // tail is only acted upon in a cycle where the owner's flit moves.

    // Rotate requests so that bit 0 is the pointer position, then take the
    // lowest set bit and rotate the offset back into an absolute index.
    always_comb begin
        req_rot  = NREQ'({req, req} >> ptr_q);
        pick_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_off = SELW'(i);
            end
        end
        pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
        if (pick_sum >= NREQ_EXT) begin
            pick_sum = pick_sum - NREQ_EXT;
        end
        pick = pick_sum[SELW-1:0];
    end

    assign owner_req  = |(req & gnt_q);
    assign owner_tail = |(tail & gnt_q);
    assign fwd        = (state_q == ST_BUSY) && owner_req && (credit_cnt_q != '0);
    assign pkt_done   = (fwd && owner_tail) || wd_fire;

`ifdef WATCHDOG_EN
    logic [3:0] stall_q, stall_d;
    logic       wd_trip_q, wd_trip_d;

    // Counts consecutive non-forwarding cycles of the current lock; the cycle
    // that would make the count reach WD_LIMIT releases the lock instead.
    always_comb begin
        stall_d = '0;
        wd_fire = 1'b0;
        if (state_q == ST_BUSY && !fwd) begin
            wd_fire = (stall_q == 4'(WD_LIMIT - 1));
            stall_d = wd_fire ? 4'd0 : stall_q + 4'd1;
        end
        wd_trip_d = wd_fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q   <= '0;
            wd_trip_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            wd_trip_q <= wd_trip_d;
        end
    end

    assign wd_trip = wd_trip_q;
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_BUSY;
                    sel_d   = pick;
                    gnt_d   = GNT_ONE << pick;
                end
            end
            ST_BUSY: begin
                if (pkt_done) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                    gnt_d   = '0;
                    ptr_d   = (sel_q == LAST_IDX) ? '0 : sel_q + ONE_IDX;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                gnt_d   = '0;
            end
        endcase
    end

    // A returned credit and a forwarded flit in the same cycle cancel out.
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;
        if (fwd && !credit_in) begin
            credit_cnt_d = credit_cnt_q - CRED_ONE;
        end else if (credit_in && !fwd) begin
            if (credit_cnt_q == CRED_MAX) begin
                credit_err_d = 1'b1;
            end else begin
                credit_cnt_d = credit_cnt_q + CRED_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            sel_q        <= '0;
            gnt_q        <= '0;
            credit_cnt_q <= CRED_MAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            gnt_q        <= gnt_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign busy       = (state_q == ST_BUSY);
    assign credit_cnt = credit_cnt_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_wormhole_rr_allocator.sv
// Bench for wormhole_rr_allocator: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the allocation rules.
module tb_wormhole_rr_allocator;

    localparam int NREQ     = 10;
    localparam int CREDITS  = 4;
    localparam int WD_LIMIT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] req;
    logic [9:0] tail;
    logic       credit_in;
    logic [9:0] gnt;
    logic [3:0] sel;
    logic       fwd;
    logic       busy;
    logic [2:0] credit_cnt;
    logic       credit_err;
    logic       wd_obs;

    always #5 clk = ~clk;

`ifdef WATCHDOG_EN
    logic wd_trip;
    assign wd_obs = wd_trip;
`else
    assign wd_obs = 1'b0;
`endif

    wormhole_rr_allocator dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .tail       (tail),
        .credit_in  (credit_in),
        .gnt        (gnt),
        .sel        (sel),
        .fwd        (fwd),
        .busy       (busy),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
`ifdef WATCHDOG_EN
        ,
        .wd_trip    (wd_trip)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cred;
    int m_stall;
    bit m_err;
    bit m_wd;
    logic [3:0] exp_q[$];

    // Observed / expected for the most recent cycle
    logic [9:0]  o_gnt;
    logic [3:0]  o_sel;
    logic        o_fwd, o_busy, o_err, o_wd;
    logic [2:0]  o_cnt;
    logic [20:0] obs, exp_v;

    function automatic bit has(input logic [9:0] v, input int k);
        return ((v >> k) & 10'd1) != 10'd0;
    endfunction

    function automatic logic [20:0] model_out(input logic [9:0] r);
        logic [9:0] g;
        logic [3:0] s;
        logic       f;
        g = m_busy ? (10'd1 << m_owner) : 10'd0;
        s = m_busy ? 4'(m_owner) : 4'd0;
        f = m_busy && has(r, m_owner) && (m_cred > 0);
        return {g, s, f, m_busy, 3'(m_cred), m_err, m_wd};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cred = CREDITS;
        m_stall = 0; m_err = 0; m_wd = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [9:0] r, input logic [9:0] t, input logic c);
        bit f, done, found;
        int o;
        f = m_busy && has(r, m_owner) && (m_cred > 0);
        m_wd = 0;
        if (f && !c) m_cred--;
        else if (c && !f) begin
            if (m_cred == CREDITS) m_err = 1;
            else m_cred++;
        end
        if (!m_busy) begin
            m_stall = 0;
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                o = (m_ptr + k) % NREQ;
                if (!found && has(r, o)) begin
                    found = 1;
                    m_owner = o;
                end
            end
            if (found) begin
                m_busy = 1;
                exp_q.push_back(4'(m_owner));
            end
        end else begin
            done = f && has(t, m_owner);
`ifdef WATCHDOG_EN
            if (f) m_stall = 0;
            else begin
                m_stall++;
                if (m_stall == WD_LIMIT) begin
                    done = 1;
                    m_wd = 1;
                end
            end
`endif
            if (done) begin
                m_busy = 0;
                m_ptr = (m_owner + 1) % NREQ;
                m_stall = 0;
            end
        end
    endtask

    // Drives one cycle of inputs, samples just after the falling edge, then
    // advances the model on the rising edge.
    task automatic cycle(input logic [9:0] r, input logic [9:0] t, input logic c);
        @(negedge clk);
        req = r; tail = t; credit_in = c;
        #1;
        o_gnt = gnt; o_sel = sel; o_fwd = fwd; o_busy = busy;
        o_cnt = credit_cnt; o_err = credit_err; o_wd = wd_obs;
        obs = {o_gnt, o_sel, o_fwd, o_busy, o_cnt, o_err, o_wd};
        exp_v = model_out(r);
        @(posedge clk);
        model_step(r, t, c);
    endtask

    task automatic restore_credits();
        for (int i = 0; i < 8; i++) begin
            if (m_cred < CREDITS && !m_busy) cycle(10'd0, 10'd0, 1'b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_tests++;
        if ({gnt, sel, busy, fwd, credit_cnt, credit_err} !== {10'd0, 4'd0, 1'b0, 1'b0, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: gnt=%b sel=%0d busy=%b fwd=%b cnt=%0d err=%b, want 0/0/0/0/4/0",
                     gnt, sel, busy, fwd, credit_cnt, credit_err);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        int nf = 0;
        cycle(10'b0000010100, 10'd0, 1'b0);
        n_tests++;
        if (obs !== exp_v || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle: got %h want %h", obs, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(10'b0000010100, (i == 2) ? 10'b0000000100 : 10'd0, 1'b0);
            nf += int'(o_fwd);
            n_tests++;
            if (obs !== exp_v || o_sel !== 4'd2 || o_gnt !== 10'b0000000100) begin
                n_fail++; $display("FAIL basic_flit%0d: got %h want %h (sel=%0d)", i, obs, exp_v, o_sel);
            end
        end
        cycle(10'd0, 10'd0, 1'b0);
        n_tests++;
        if (obs !== exp_v || o_busy !== 1'b0 || nf != 3) begin
            n_fail++; $display("FAIL basic_release: got %h want %h fwd_count=%0d want 3", obs, exp_v, nf);
        end
        restore_credits();
    endtask

    task automatic test_rr_order();
        logic [3:0] want_sel [4] = '{4'd0, 4'd3, 4'd0, 4'd2};
        logic       want_bsy [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cycle(10'b0000001100, 10'b0000001100, 1'b0);
            n_tests++;
            if (obs !== exp_v || o_sel !== want_sel[i] || o_busy !== want_bsy[i]) begin
                n_fail++; $display("FAIL rr_order%0d: got %h want %h sel=%0d want %0d", i, obs, exp_v, o_sel, want_sel[i]);
            end
        end
        cycle(10'd0, 10'd0, 1'b0);
        restore_credits();
    endtask

    task automatic test_wrap();
        logic [9:0] rq [4] = '{10'h200, 10'h200, 10'h201, 10'h201};
        logic [9:0] tl [4] = '{10'h200, 10'h200, 10'h001, 10'h001};
        logic [3:0] ws [4] = '{4'd0, 4'd9, 4'd0, 4'd0};
        logic       wb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cycle(rq[i], tl[i], 1'b0);
            n_tests++;
            if (obs !== exp_v || o_sel !== ws[i] || o_busy !== wb[i]) begin
                n_fail++; $display("FAIL wrap%0d: got %h want %h sel=%0d want %0d", i, obs, exp_v, o_sel, ws[i]);
            end
        end
        cycle(10'd0, 10'd0, 1'b0);
        restore_credits();
    endtask

    task automatic test_credit_stall();
        int nf = 0;
        cycle(10'h020, 10'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(10'h020, 10'd0, 1'b0);
            nf += int'(o_fwd);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL credit_drain%0d: got %h want %h", i, obs, exp_v);
            end
        end
        n_tests++;
        if (nf != 4 || o_cnt !== 3'd0 || o_fwd !== 1'b0) begin
            n_fail++; $display("FAIL credit_block: fwd_count=%0d cnt=%0d fwd=%b want 4/0/0", nf, o_cnt, o_fwd);
        end
        cycle(10'h020, 10'd0, 1'b1);
        nf = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(10'h020, 10'd0, 1'b0);
            nf += int'(o_fwd);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL credit_one%0d: got %h want %h", i, obs, exp_v);
            end
        end
        n_tests++;
        if (nf != 1) begin
            n_fail++; $display("FAIL credit_one_flit: fwd_count=%0d want 1", nf);
        end
        cycle(10'h020, 10'd0, 1'b1);
        cycle(10'h020, 10'h020, 1'b0);
        n_tests++;
        if (obs !== exp_v || o_fwd !== 1'b1) begin
            n_fail++; $display("FAIL credit_tail: got %h want %h", obs, exp_v);
        end
        cycle(10'd0, 10'd0, 1'b0);
        restore_credits();
    endtask

    task automatic test_credit_err();
        cycle(10'h002, 10'd0, 1'b0);
        cycle(10'h002, 10'd0, 1'b1);
        n_tests++;
        if (obs !== exp_v || o_fwd !== 1'b1 || o_cnt !== 3'd4) begin
            n_fail++; $display("FAIL fwd_and_credit: got %h want %h", obs, exp_v);
        end
        cycle(10'h002, 10'h002, 1'b1);
        n_tests++;
        if (obs !== exp_v || o_cnt !== 3'd4) begin
            n_fail++; $display("FAIL fwd_and_credit_hold: cnt=%0d want 4", o_cnt);
        end
        cycle(10'd0, 10'd0, 1'b1);
        n_tests++;
        if (obs !== exp_v || o_err !== 1'b0 || o_cnt !== 3'd4) begin
            n_fail++; $display("FAIL credit_overflow_pre: got %h want %h", obs, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(10'd0, 10'd0, 1'b0);
            n_tests++;
            if (obs !== exp_v || o_err !== 1'b1 || o_cnt !== 3'd4) begin
                n_fail++; $display("FAIL credit_err_sticky%0d: err=%b cnt=%0d want 1/4", i, o_err, o_cnt);
            end
        end
    endtask

    task automatic test_stall();
        cycle(10'h040, 10'd0, 1'b0);
        cycle(10'h040, 10'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(10'h080, 10'd0, 1'b0);
            n_tests++;
            if (obs !== exp_v || (i < 15 && (o_busy !== 1'b1 || o_sel !== 4'd6 || o_fwd !== 1'b0))) begin
                n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, exp_v);
            end
        end
        for (int i = 0; i < 40; i++) begin
            if (m_busy) begin
                cycle(10'd1 << m_owner, 10'd1 << m_owner, 1'(m_cred == 0));
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++; $display("FAIL stall_finish%0d: got %h want %h", i, obs, exp_v);
                end
            end
        end
        cycle(10'd0, 10'd0, 1'b0);
        n_tests++;
        if (obs !== exp_v || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL stall_end: got %h want %h", obs, exp_v);
        end
        restore_credits();
    endtask

    task automatic test_reset_mid();
        cycle(10'h100, 10'd0, 1'b0);
        cycle(10'h100, 10'd0, 1'b0);
        cycle(10'h100, 10'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1; req = '0;
        #1;
        n_tests++;
        if ({gnt, sel, busy, credit_cnt, credit_err} !== {10'd0, 4'd0, 1'b0, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: gnt=%b sel=%0d busy=%b cnt=%0d err=%b, want 0/0/0/4/0",
                     gnt, sel, busy, credit_cnt, credit_err);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [9:0] r, t;
        logic       c;
        logic       prev_busy;
        logic [3:0] want;
        exp_q.delete();
        prev_busy = m_busy;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 4) == 0) ? 10'd0 : (10'($urandom) & 10'($urandom));
            t = ($urandom_range(0, 2) == 0) ? 10'($urandom) : 10'd0;
            c = 1'($urandom_range(0, 3) == 0);
            cycle(r, t, c);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL random%0d: got %h want %h", i, obs, exp_v);
            end
            if (o_busy && !prev_busy) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL random_grant%0d: grant to %0d with none expected", i, o_sel);
                end else begin
                    want = exp_q.pop_front();
                    if (o_sel !== want) begin
                        n_fail++; $display("FAIL random_grant%0d: sel=%0d want %0d", i, o_sel, want);
                    end
                end
            end
            prev_busy = o_busy;
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_rr_order();
        test_wrap();
        test_credit_stall();
        test_credit_err();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
